// File: rtl/pc_seq_ctrl.sv
// PC sequencing control: issues branch redirects to the PC adder, holds them across
// instruction-memory back-pressure, and masks branches in a post-redirect shadow window.
// Optional performance counters (stall_cnt, redir_cnt) are built when PC_SEQ_CTRL_PERF_EN is defined.
module pc_seq_ctrl #(
    parameter int SHADOW_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    output logic        pc_stop,
    output logic        jump_start,
    output logic [31:0] pc_jump,
    output logic        flush_if,
    output logic        flush_id,
    output logic [1:0]  state
`ifdef PC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PEND   = 2'b01,
        SHADOW = 2'b10
    } state_e;

    // A zero-length window behaves as one cycle; the 2-bit counter caps the window at four.
    localparam int SH_EFF = (SHADOW_CYC < 1) ? 1 : ((SHADOW_CYC > 4) ? 4 : SHADOW_CYC);
    localparam logic [1:0] SH_INIT = 2'(SH_EFF - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] off_q, off_d;

    logic        accept;
    logic        stop_c, js_c, fi_c, fd_c;
    logic [31:0] jump_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            off_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
        end
    end

    // imem_ready is a ready-only handshake: a redirect is consumed by the PC adder only in a
    // cycle where imem_ready=1; otherwise the offset is parked in off_q and the PC stays frozen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        js_c    = 1'b0;
        jump_c  = 32'd0;
        fi_c    = 1'b0;
        fd_c    = 1'b0;
        accept  = 1'b0;

        case (state_q)
            RUN:     accept = br_taken;
            SHADOW:  accept = br_taken && (cnt_q == 2'd0);
            default: accept = 1'b0;
        endcase

        if (state_q == PEND) begin
            fi_c = 1'b1;
            if (imem_ready) begin
                js_c    = 1'b1;
                jump_c  = off_q;
                state_d = SHADOW;
                cnt_d   = SH_INIT;
            end
        end else if (accept) begin
            // The flushes also kill any instruction that was raising hazard_stall.
            fi_c = 1'b1;
            fd_c = 1'b1;
            if (imem_ready) begin
                js_c    = 1'b1;
                jump_c  = br_offset;
                state_d = SHADOW;
                cnt_d   = SH_INIT;
            end else begin
                off_d   = br_offset;
                state_d = PEND;
            end
        end else begin
            fd_c = hazard_stall;
            if (state_q == SHADOW && cnt_q != 2'd0) begin
                cnt_d = cnt_q - 2'd1;
            end else begin
                state_d = RUN;
            end
        end

        stop_c = ~imem_ready | (hazard_stall & ~accept & (state_q != PEND));
    end

    // Outputs are held quiet for the whole time reset is asserted.
    assign pc_stop    = reset_n & stop_c;
    assign jump_start = reset_n & js_c;
    assign pc_jump    = reset_n ? jump_c : 32'd0;
    assign flush_if   = reset_n & fi_c;
    assign flush_id   = reset_n & fd_c;
    assign state      = state_q;

`ifdef PC_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 32'd0;
            redir_cnt <= 32'd0;
        end else begin
            if (pc_stop && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (jump_start && redir_cnt != 32'hFFFF_FFFF) begin
                redir_cnt <= redir_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
